// File: rtl/pulse_seq_scheduler_if.sv
// Host-side bundle for the pulse sequencer: table writes, run control and status/pulse bus.
interface pulse_seq_scheduler_if #(
   parameter int unsigned DUR_W = 32,
   parameter int unsigned PAT_W = 8,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned REP_W = 16
);
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_addr;
   logic [DUR_W-1:0] cfg_dur;
   logic [PAT_W-1:0] cfg_pat;
   logic [IDX_W-1:0] seq_len;
   logic [REP_W-1:0] rep_cnt;
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic [IDX_W-1:0] step_idx;
   logic [PAT_W-1:0] signal_out;

   // Host/config side.
   modport master (
      output cfg_we, cfg_addr, cfg_dur, cfg_pat, seq_len, rep_cnt, start, abort,
      input  busy, done, cfg_err, step_idx, signal_out
   );

   // Sequencer side.
   modport slave (
      input  cfg_we, cfg_addr, cfg_dur, cfg_pat, seq_len, rep_cnt, start, abort,
      output busy, done, cfg_err, step_idx, signal_out
   );
endinterface

// File: rtl/pulse_seq_scheduler.sv
// Run-time programmable pulse sequencer: steps through a loaded duration/pattern table,
// repeating a bounded or unbounded number of passes, and drives a registered pulse bus.
module pulse_seq_scheduler #(
   parameter int unsigned      NUM_STEPS = 12,
   parameter int unsigned      DUR_W     = 32,
   parameter int unsigned      PAT_W     = 8,
   parameter int unsigned      IDX_W     = 4,
   parameter int unsigned      REP_W     = 16,
   parameter logic [PAT_W-1:0] IDLE_PAT  = 'h80
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   pulse_seq_scheduler_if.slave  bus
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   // One extra bit so NUM_STEPS == 2^IDX_W still compares correctly.
   localparam logic [IDX_W:0] NumStepsW = (IDX_W + 1)'(NUM_STEPS);

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] step_q, step_d;
   logic [DUR_W-1:0] timer_q, timer_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic [REP_W-1:0] rem_q, rem_d;
   logic [PAT_W-1:0] sig_q, sig_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [DUR_W-1:0] dur_q [NUM_STEPS];
   logic [PAT_W-1:0] pat_q [NUM_STEPS];

   logic wr_en;
   logic addr_ok;
   logic len_ok;
   logic last_step;

   assign addr_ok   = {1'b0, bus.cfg_addr} < NumStepsW;
   assign len_ok    = (bus.seq_len != '0) && ({1'b0, bus.seq_len} <= NumStepsW);
   assign last_step = step_q == (len_q - IDX_W'(1));

   // Next-state: write acceptance, start/abort handling and step sequencing.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      timer_d = timer_q;
      len_d   = len_q;
      rem_d   = rem_q;
      sig_d   = sig_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      if (bus.cfg_we) begin
         if (state_q == StIdle && addr_ok) begin
            wr_en = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         StIdle: begin
            // abort in IDLE blocks a coincident start without flagging an error.
            if (bus.start && !bus.abort) begin
               if (len_ok) begin
                  state_d = StRun;
                  step_d  = '0;
                  timer_d = '0;
                  len_d   = bus.seq_len;
                  rem_d   = bus.rep_cnt;
                  sig_d   = pat_q[0];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (bus.abort) begin
               state_d = StIdle;
               step_d  = '0;
               timer_d = '0;
               sig_d   = IDLE_PAT;
            end else if (timer_q == dur_q[step_q]) begin
               timer_d = '0;
               if (!last_step) begin
                  step_d = step_q + IDX_W'(1);
                  sig_d  = pat_q[step_q + IDX_W'(1)];
               end else if (rem_q != REP_W'(1)) begin
                  // rem_q == 0 means run forever, so only decrement a finite count.
                  step_d = '0;
                  sig_d  = pat_q[0];
                  if (rem_q != '0) begin
                     rem_d = rem_q - REP_W'(1);
                  end
               end else begin
                  state_d = StIdle;
                  step_d  = '0;
                  sig_d   = IDLE_PAT;
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + DUR_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            sig_d   = IDLE_PAT;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= StIdle;
         step_q  <= '0;
         timer_q <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         sig_q   <= IDLE_PAT;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         timer_q <= timer_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         sig_q   <= sig_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Step table; a start in the same cycle as a write still sees the old contents.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            dur_q[i] <= '0;
            pat_q[i] <= IDLE_PAT;
         end
      end else begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            if (wr_en && bus.cfg_addr == IDX_W'(i)) begin
               dur_q[i] <= bus.cfg_dur;
               pat_q[i] <= bus.cfg_pat;
            end
         end
      end
   end

   assign bus.busy       = (state_q == StRun);
   assign bus.done       = done_q;
   assign bus.cfg_err    = err_q;
   assign bus.step_idx   = step_q;
   assign bus.signal_out = sig_q;

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Directed bench for pulse_seq_scheduler: a table model generates the expected per-cycle
// bus trace into a scoreboard queue, which is popped and compared one entry per clock.
module tb_pulse_seq_scheduler;

   typedef struct packed {
      logic [7:0] pat;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] step;
   } exp_t;

   localparam exp_t IdleExp = '{pat: 8'h80, busy: 1'b0, done: 1'b0, err: 1'b0, step: 4'd0};

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;

   pulse_seq_scheduler_if #(.DUR_W(32), .PAT_W(8), .IDX_W(4), .REP_W(16)) bus ();

   pulse_seq_scheduler #(
      .NUM_STEPS(12), .DUR_W(32), .PAT_W(8), .IDX_W(4), .REP_W(16), .IDLE_PAT(8'h80)
   ) dut (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .bus     (bus)
   );

   always #5 clk_in = ~clk_in;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   logic [31:0] m_dur [12];
   logic [7:0]  m_pat [12];

   function automatic exp_t observed();
      return '{pat: bus.signal_out, busy: bus.busy, done: bus.done, err: bus.cfg_err,
               step: bus.step_idx};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 12; i++) begin
         m_dur[i] = '0;
         m_pat[i] = 8'h80;
      end
   endtask

   task automatic cfg_write(input int addr, input logic [31:0] dur, input logic [7:0] pat);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(addr);
      bus.cfg_dur  = dur;
      bus.cfg_pat  = pat;
      tick();
      bus.cfg_we = 1'b0;
      if (addr < 12) begin
         m_dur[addr] = dur;
         m_pat[addr] = pat;
      end
   endtask

   // Expected trace for `passes` full passes, optionally followed by the done cycle.
   task automatic push_run(input int len, input int passes, input bit with_done);
      for (int p = 0; p < passes; p++)
         for (int s = 0; s < len; s++)
            for (int c = 0; c <= int'(m_dur[s]); c++)
               sb.push_back('{pat: m_pat[s], busy: 1'b1, done: 1'b0, err: 1'b0, step: 4'(s)});
      if (with_done) sb.push_back('{pat: 8'h80, busy: 1'b0, done: 1'b1, err: 1'b0, step: 4'd0});
   endtask

   task automatic start_seq(input int len, input int rep);
      bus.seq_len = 4'(len);
      bus.rep_cnt = 16'(rep);
      bus.start   = 1'b1;
   endtask

   // Pops `count` entries, one per edge; optionally issues a table write sampled at edge we_at.
   task automatic drain(input string tag, input int count, input int we_at);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         tick();
         bus.start  = 1'b0;
         bus.cfg_we = 1'b0;
         e = sb.pop_front();
         check($sformatf("%s[%0d]", tag, i), 32'(observed()), 32'(e));
         if (i + 1 == we_at) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 4'd1;
            bus.cfg_dur  = 32'd50;
            bus.cfg_pat  = 8'h55;
         end
      end
   endtask

   initial begin
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_dur  = '0;
      bus.cfg_pat  = '0;
      bus.seq_len  = '0;
      bus.rep_cnt  = '0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      model_reset();
      #12;
      check("reset_state", 32'(observed()), 32'(IdleExp));
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
      check("post_reset_idle", 32'(observed()), 32'(IdleExp));

      // Single pass: 0x88 x3, 0x80 x1, 0x90 x5, then done.
      cfg_write(0, 32'd2, 8'h88);
      cfg_write(1, 32'd0, 8'h80);
      cfg_write(2, 32'd4, 8'h90);
      start_seq(3, 1);
      push_run(3, 1, 1'b1);
      drain("single_pass", sb.size(), -1);
      tick();
      check("done_one_cycle", 32'(observed()), 32'(IdleExp));

      // Two passes back to back.
      start_seq(3, 2);
      push_run(3, 2, 1'b1);
      drain("two_pass", sb.size(), -1);

      // Infinite run: 11 passes (99 cycles), then abort on the wrap boundary edge.
      start_seq(3, 0);
      push_run(3, 11, 1'b0);
      drain("infinite", sb.size(), -1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_idle", 32'(observed()), 32'(IdleExp));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("abort_no_done[%0d]", i), 32'(observed()), 32'(IdleExp));
      end

      // Write during RUN is rejected; rerun timing proves entry 1 kept dur=0.
      start_seq(3, 1);
      push_run(3, 1, 1'b1);
      sb[2].err = 1'b1;
      drain("run_write", sb.size(), 2);
      start_seq(3, 1);
      push_run(3, 1, 1'b1);
      drain("rerun_after_write", sb.size(), -1);

      // Out-of-range write in IDLE.
      cfg_write(12, 32'd7, 8'h11);
      check("addr12_err", 32'(observed()), 32'({8'h80, 1'b0, 1'b0, 1'b1, 4'd0}));
      tick();
      check("addr12_err_clear", 32'(observed()), 32'(IdleExp));

      // Illegal sequence lengths.
      start_seq(0, 1);
      tick();
      bus.start = 1'b0;
      check("len0_err", 32'(observed()), 32'({8'h80, 1'b0, 1'b0, 1'b1, 4'd0}));
      start_seq(13, 1);
      tick();
      bus.start = 1'b0;
      check("len13_err", 32'(observed()), 32'({8'h80, 1'b0, 1'b0, 1'b1, 4'd0}));
      tick();
      check("len_err_clear", 32'(observed()), 32'(IdleExp));

      // Async reset while 0x90 is on the bus.
      start_seq(3, 0);
      push_run(3, 1, 1'b0);
      drain("pre_reset", 6, -1);
      sb.delete();
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_sig", 32'(bus.signal_out), 32'h80);
      check("async_rst_busy", 32'(bus.busy), 32'h0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
      tick();
      check("post_async_idle", 32'(observed()), 32'(IdleExp));
      start_seq(3, 1);
      push_run(3, 1, 1'b1);
      drain("rerun_reset_table", sb.size(), -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pulse_seq_scheduler.md
Name: pulse_seq_scheduler

Overview:
- Programmable sequencer that replaces the fixed R/W/M pulse table with a run-time loaded step table.
- Host/config logic writes per-step duration and output pattern, then issues start with a repeat count. The block steps through the table and drives the 8-bit pulse bus to the pulse driver.
- Provides busy/done/abort control so the host can run a bounded number of measurement cycles or run continuously.

Parameters:
- NUM_STEPS, 12, table depth; legal sequence length is 1..NUM_STEPS.
- DUR_W, 32, width of a step-duration word.
- PAT_W, 8, width of the output pattern.
- IDX_W, 4, width of step index/address; must satisfy 2^IDX_W >= NUM_STEPS.
- REP_W, 16, width of the repeat counter.
- IDLE_PAT, 8'b1000_0000, pattern driven when not running.

Ports:
- clk_in, input, 1, clock.
- rst_n_in, input, 1, reset; asynchronous, active-low.
- cfg_we, input, 1, table write strobe.
- cfg_addr, input, IDX_W, table entry to write.
- cfg_dur, input, DUR_W, step duration in cycles, minus 1.
- cfg_pat, input, PAT_W, step output pattern.
- seq_len, input, IDX_W, number of active steps; sampled at start.
- rep_cnt, input, REP_W, number of full passes; 0 means run until abort. Sampled at start.
- start, input, 1, level-sampled start request.
- abort, input, 1, stop request.
- busy, output, 1, high while a sequence is running.
- done, output, 1, one-cycle pulse on normal completion.
- cfg_err, output, 1, one-cycle pulse on any rejected write or start.
- step_idx, output, IDX_W, current step.
- signal_out, output, PAT_W, registered pulse bus.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Outputs: signal_out=IDLE_PAT, busy=0, done=0, cfg_err=0, step_idx=0.
  - Internal state: all table durations 0, all table patterns IDLE_PAT, timer 0, state IDLE.
  - Reset mid-run: signal_out returns to IDLE_PAT immediately; no done pulse.
- States:
  - IDLE: busy=0, signal_out=IDLE_PAT.
  - RUN: busy=1.
- Table writes:
  - Accepted only in IDLE, when cfg_we=1 and cfg_addr<NUM_STEPS. The entry is updated at that edge.
  - A write in RUN, or to cfg_addr>=NUM_STEPS, is dropped and pulses cfg_err the next cycle.
- Start (IDLE only): start=1 at edge k with 1<=seq_len<=NUM_STEPS and abort=0 causes, at edge k:
  - seq_len and rep_cnt are latched.
  - state=RUN, step_idx=0, timer=0.
  - signal_out=pat[0], busy=1.
  - Latency from start sample to first pattern: 1 cycle.
- Start rejection:
  - start with seq_len=0 or seq_len>NUM_STEPS: pulse cfg_err and stay in IDLE.
  - start during RUN: ignored silently.
  - start and cfg_we in the same IDLE cycle: the write is performed and start uses the pre-write table for that edge. Entry 0 must therefore be written at least one cycle before start.
- Step timing: each step's pattern is held for dur[i]+1 cycles. The timer increments each RUN cycle; at the edge where timer==dur[step_idx] (compare on full DUR_W, unsigned):
  - Not last step: step_idx+1, timer=0, signal_out=pat[step_idx+1]. No gap cycle between steps.
  - Last step (step_idx==seq_len-1), and rep_cnt latched 0 or remaining passes >1: step_idx=0, timer=0, signal_out=pat[0], remaining decrements (no decrement when 0=infinite).
  - Last step of the final pass: state=IDLE, signal_out=IDLE_PAT, busy=0, done=1 for exactly that one cycle.
- Abort:
  - abort=1 in RUN at any edge: state=IDLE, signal_out=IDLE_PAT, busy=0, timer=0, step_idx=0, no done pulse.
  - abort has priority over a step transition in the same cycle.
  - abort in IDLE has no effect and blocks a coincident start.
- Latched snapshot: seq_len and rep_cnt changes during RUN have no effect. Table contents cannot change during RUN.
- Arithmetic:
  - The timer is DUR_W wide and never wraps in normal operation, because it resets at dur.
  - dur=2^DUR_W-1 gives 2^DUR_W cycles.
  - The remaining-pass counter is REP_W wide.

Test Plan:
- Reset then load table entries 0..2 with dur=2,0,4 and pat=0x88,0x80,0x90; seq_len=3, rep_cnt=1; pulse start -> signal_out = 0x88 for 3 cycles, then 0x80 for 1, then 0x90 for 5. The next cycle is 0x80 (IDLE_PAT) with done=1 for 1 cycle; busy was high for exactly 9 cycles.
- Same table with rep_cnt=2 -> the 9-cycle pattern appears twice back-to-back with no gap, done pulses once after cycle 18, step_idx wraps 2->0 once.
- rep_cnt=0, run 100 cycles, assert abort coincident with a step boundary -> next cycle signal_out=0x80, busy=0, done never asserted, step_idx=0.
- cfg_we during RUN to addr 1 with dur=50 -> cfg_err pulses, and after completion the table still holds dur=0 at entry 1 (verify by rerun timing). A write to addr 12 in IDLE -> cfg_err, no table change.
- start with seq_len=0, then with seq_len=13 -> cfg_err each time, busy stays 0, signal_out stays 0x80.
- Assert rst_n_in low asynchronously mid-step with signal_out=0x90 -> signal_out=0x80 and busy=0 before the next clock edge. After release, a rerun without reloading drives IDLE_PAT patterns with 1-cycle steps.
